// File: rtl/fetch_queue_pkg.sv
// Shared types and sizes for the fetch-to-decode queue.
package fetch_queue_pkg;

    localparam int FETCH_WIDTH  = 2;
    localparam int DECODE_WIDTH = 2;
    localparam int FQ_DEPTH     = 16;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        pred_taken;
    } fq_entry_t;

endpackage

// File: rtl/fq_compact.sv
// Turns a per-slot enqueue mask into dense write offsets and a slot count.
// Each slot's offset is the number of valid slots below it, so the valid
// slots land back-to-back starting at the tail.
module fq_compact
    import fetch_queue_pkg::*;
#(
    parameter int FW = FETCH_WIDTH
) (
    input  logic [FW-1:0]                    mask_i,
    output logic [FW-1:0][$clog2(FW+1)-1:0]  offset_o,
    output logic [$clog2(FW+1)-1:0]          num_o
);

    localparam int OW = $clog2(FW+1);

    logic [OW-1:0] acc;

    // Running popcount of the mask, sampled before each slot is added.
    always_comb begin
        acc      = '0;
        offset_o = '0;
        for (int k = 0; k < FW; k++) begin
            offset_o[k] = acc;
            acc         = acc + OW'(mask_i[k]);
        end
        num_o = acc;
    end

endmodule

// File: rtl/fetch_queue.sv
// Decoupling FIFO between fetch and decode. Circular storage with a separate
// occupancy counter; enqueue readiness depends only on the registered count,
// so nothing on the decode side reaches back combinationally to fetch.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int FW    = FETCH_WIDTH,
    parameter int DW    = DECODE_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         flush_i,
    input  logic                         enq_valid_i,
    input  logic [FW-1:0]                enq_mask_i,
    input  fq_entry_t [FW-1:0]           enq_entry_i,
    output logic                         enq_ready_o,
    output logic [DW-1:0]                deq_valid_o,
    output fq_entry_t [DW-1:0]           deq_entry_o,
    input  logic [$clog2(DW+1)-1:0]      deq_num_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int OW = $clog2(FW+1);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    fq_entry_t mem_q [DEPTH];

    logic [FW-1:0][OW-1:0] offset;
    logic [OW-1:0]         enq_num;
    logic                  enq_fire;
    logic [CW-1:0]         n_enq;
    logic [CW-1:0]         deq_avail;
    logic [CW-1:0]         deq_eff;
    logic [PW-1:0]         wr_idx [FW];

    fq_compact #(.FW(FW)) u_compact (
        .mask_i   (enq_mask_i),
        .offset_o (offset),
        .num_o    (enq_num)
    );

    assign enq_ready_o = (CW'(DEPTH) - count_q) >= CW'(FW);
    assign enq_fire    = enq_valid_i && enq_ready_o && !flush_i;
    assign n_enq       = enq_fire ? CW'(enq_num) : '0;
    assign count_o     = count_q;

    // Decode may not take more than it can see; excess requests are clamped.
    always_comb begin
        deq_avail = (count_q < CW'(DW)) ? count_q : CW'(DW);
        deq_eff   = (CW'(deq_num_i) > deq_avail) ? deq_avail : CW'(deq_num_i);
    end

    // Next pointer/count state; a flush discards everything in flight this cycle.
    always_comb begin
        head_d  = head_q + PW'(deq_eff);
        tail_d  = tail_q + PW'(n_enq);
        count_d = count_q + n_enq - deq_eff;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Write addresses wrap naturally through the pointer width.
    always_comb begin
        for (int k = 0; k < FW; k++) begin
            wr_idx[k] = tail_q + PW'(offset[k]);
        end
    end

    // Storage writes; the array itself is never reset.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < FW; k++) begin
            if (enq_fire && enq_mask_i[k]) begin
                mem_q[wr_idx[k]] <= enq_entry_i[k];
            end
        end
    end

    // Oldest entries presented to decode straight from storage.
    always_comb begin
        for (int i = 0; i < DW; i++) begin
            deq_valid_o[i] = count_q > CW'(i);
            deq_entry_o[i] = mem_q[head_q + PW'(i)];
        end
    end

`ifndef SYNTHESIS
    logic pred_bug;
    logic mask_gap;

    // A taken prediction must end the packet; a gap in the mask is malformed.
    always_comb begin
        pred_bug = 1'b0;
        mask_gap = 1'b0;
        for (int k = 0; k < FW; k++) begin
            for (int j = k + 1; j < FW; j++) begin
                if (enq_mask_i[k] && enq_mask_i[j] && enq_entry_i[k].pred_taken) begin
                    pred_bug = 1'b1;
                end
                if (!enq_mask_i[k] && enq_mask_i[j]) begin
                    mask_gap = 1'b1;
                end
            end
        end
    end

    a_pred_taken_last: assert property (@(posedge clk_i) disable iff (reset_i)
        !(enq_valid_i && pred_bug));
    a_mask_contig: assert property (@(posedge clk_i) disable iff (reset_i)
        !(enq_valid_i && mask_gap));
    a_deq_legal: assert property (@(posedge clk_i) disable iff (reset_i)
        !(CW'(deq_num_i) > deq_avail));
    a_count_bound: assert property (@(posedge clk_i) disable iff (reset_i)
        count_q <= CW'(DEPTH));
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic                 enq_valid;
    logic [1:0]           enq_mask;
    fq_entry_t [1:0]      enq_entry;
    logic                 enq_ready;
    logic [1:0]           deq_valid;
    fq_entry_t [1:0]      deq_entry;
    logic [1:0]           deq_num;
    logic [4:0]           count;

    int n_chk = 0;
    int n_bad = 0;

    fq_entry_t model_q [$];

    fetch_queue dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .flush_i     (flush),
        .enq_valid_i (enq_valid),
        .enq_mask_i  (enq_mask),
        .enq_entry_i (enq_entry),
        .enq_ready_o (enq_ready),
        .deq_valid_o (deq_valid),
        .deq_entry_o (deq_entry),
        .deq_num_i   (deq_num),
        .count_o     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int min2(input int a);
        return (a < 2) ? a : 2;
    endfunction

    task automatic set_in(input logic v, input logic [1:0] m, input logic [63:0] pc0,
                          input logic [63:0] pc1, input int dn, input logic fl);
        enq_valid            = v;
        enq_mask             = m;
        enq_entry[0].pc      = pc0;
        enq_entry[0].instr   = $urandom;
        enq_entry[0].pred_taken = (m == 2'b11) ? 1'b0 : 1'($urandom_range(0, 1));
        enq_entry[1].pc      = pc1;
        enq_entry[1].instr   = $urandom;
        enq_entry[1].pred_taken = 1'($urandom_range(0, 1));
        deq_num              = 2'(dn);
        flush                = fl;
    endtask

    task automatic check_outputs();
        int sz;
        sz = model_q.size();
        chk("count", 128'(count), 128'(sz));
        chk("enq_ready", 128'(enq_ready), 128'((16 - sz) >= 2));
        for (int i = 0; i < 2; i++) begin
            chk("deq_valid", 128'(deq_valid[i]), 128'(sz > i));
            if (sz > i) begin
                chk("deq_entry", 128'(deq_entry[i]), 128'(model_q[i]));
            end
        end
    endtask

    // Reference behaviour: clear on reset/flush, otherwise pop the oldest
    // min(deq_num, visible) entries and append the masked slots if there was room.
    task automatic model_step();
        int  sz;
        bit  rdy;
        int  d;
        if (reset || flush) begin
            model_q.delete();
        end else begin
            sz  = model_q.size();
            rdy = (16 - sz) >= 2;
            d   = int'(deq_num);
            if (d > min2(sz)) d = min2(sz);
            for (int i = 0; i < d; i++) void'(model_q.pop_front());
            if (enq_valid && rdy) begin
                for (int k = 0; k < 2; k++) begin
                    if (enq_mask[k]) model_q.push_back(enq_entry[k]);
                end
            end
        end
    endtask

    task automatic tick();
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drain();
        for (int c = 0; c < 20 && model_q.size() > 0; c++) begin
            set_in(1'b0, 2'b00, 64'h0, 64'h0, min2(model_q.size()), 1'b0);
            tick();
        end
        chk("drained", 128'(count), 128'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(1'b0, 2'b00, 64'h0, 64'h0, 0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 2'b00, 64'h0, 64'h0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        model_q.delete();

        // Reset state and first packet.
        do_reset();
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_ready", 128'(enq_ready), 128'(1));
        chk("rst_valid", 128'(deq_valid), 128'(0));
        set_in(1'b1, 2'b11, 64'h8000_0000, 64'h8000_0004, 0, 1'b0);
        tick();
        chk("t1_count", 128'(count), 128'(2));
        chk("t1_valid", 128'(deq_valid), 128'(2'b11));
        chk("t1_pc0", 128'(deq_entry[0].pc), 128'(64'h8000_0000));

        // Fill to full, hold a packet, then free room.
        do_reset();
        for (int p = 0; p < 8; p++) begin
            set_in(1'b1, 2'b11, 64'h1000 + 64'(p * 8), 64'h1004 + 64'(p * 8), 0, 1'b0);
            tick();
        end
        chk("full_count", 128'(count), 128'(16));
        chk("full_ready", 128'(enq_ready), 128'(0));
        set_in(1'b1, 2'b11, 64'h9000, 64'h9004, 0, 1'b0);
        tick();
        tick();
        chk("held_count", 128'(count), 128'(16));
        deq_num = 2'd2;
        tick();
        chk("freed_ready", 128'(enq_ready), 128'(1));
        deq_num = 2'd0;
        tick();
        drain();

        // Partial packet compaction.
        set_in(1'b0, 2'b00, 64'h0, 64'h0, 0, 1'b1);
        tick();
        set_in(1'b1, 2'b01, 64'h100, 64'h0, 0, 1'b0);
        tick();
        set_in(1'b1, 2'b11, 64'h200, 64'h204, 0, 1'b0);
        tick();
        chk("cmp_pc0", 128'(deq_entry[0].pc), 128'(64'h100));
        chk("cmp_pc1", 128'(deq_entry[1].pc), 128'(64'h200));
        set_in(1'b0, 2'b00, 64'h0, 64'h0, 2, 1'b0);
        tick();
        chk("cmp_pc2", 128'(deq_entry[0].pc), 128'(64'h204));
        drain();

        // Wrap: tail at 15, two slots land at 15 and 0.
        do_reset();
        for (int p = 0; p < 7; p++) begin
            set_in(1'b1, 2'b11, 64'h2000 + 64'(p * 8), 64'h2004 + 64'(p * 8), 0, 1'b0);
            tick();
        end
        set_in(1'b1, 2'b01, 64'h2100, 64'h0, 0, 1'b0);
        tick();
        set_in(1'b0, 2'b00, 64'h0, 64'h0, 2, 1'b0);
        tick();
        set_in(1'b1, 2'b11, 64'hA00, 64'hA04, 0, 1'b0);
        tick();
        chk("wrap_count", 128'(count), 128'(15));
        drain();

        // Flush beats same-cycle enq and deq.
        do_reset();
        set_in(1'b1, 2'b11, 64'h10, 64'h14, 0, 1'b0);
        tick();
        set_in(1'b1, 2'b11, 64'h18, 64'h1c, 0, 1'b0);
        tick();
        chk("pre_flush", 128'(count), 128'(4));
        set_in(1'b1, 2'b11, 64'h20, 64'h24, 2, 1'b1);
        tick();
        chk("fl_count", 128'(count), 128'(0));
        chk("fl_valid", 128'(deq_valid), 128'(0));
        chk("fl_ready", 128'(enq_ready), 128'(1));
        set_in(1'b1, 2'b01, 64'h300, 64'h0, 0, 1'b0);
        tick();
        chk("fl_first", 128'(deq_entry[0].pc), 128'(64'h300));
        drain();

        // Steady state at two in, two out.
        set_in(1'b1, 2'b11, 64'h4000, 64'h4004, 0, 1'b0);
        tick();
        for (int c = 0; c < 100; c++) begin
            set_in(1'b1, 2'b11, 64'h4008 + 64'(c * 8), 64'h400c + 64'(c * 8), 2, 1'b0);
            tick();
            chk("steady_cnt", 128'(count), 128'(2));
        end
        drain();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            logic [1:0] m;
            logic [63:0] pc;
            pc = 64'h10_0000 + 64'(c * 16);
            case ($urandom_range(0, 2))
                0:       m = 2'b00;
                1:       m = 2'b01;
                default: m = 2'b11;
            endcase
            set_in(1'($urandom_range(0, 3) != 0), m, pc, pc + 64'd4,
                   $urandom_range(0, min2(model_q.size())),
                   1'($urandom_range(0, 31) == 0));
            tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
